fpu_share_arbiter: RTL
======================

Name: fpu_share_arbiter

Overview:
- Shares the single ieee754_sp floating-point unit between NREQ independent requesters, e.g. several multicycle cores or a core plus a vector/DMA engine.
- Arbitrates round-robin and issues one operation at a time over the unit's go/done handshake.
- Holds the operands and opcode stable for the whole operation, then routes the result back to the requester that issued it.
- A watchdog converts a hung unit into an error response so that no requester can deadlock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum number of cycles spent in WAIT before the operation is aborted (>=2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant; a request is accepted on valid&ready.
- req_op  in  2*NREQ  per-requester opcode, slice i = [2i+1:2i]; 0=MULT, 1=DIV, 2=ADD, 3=SUB.
- req_a  in  32*NREQ  per-requester operand a, slice [32i+31:32i].
- req_b  in  32*NREQ  per-requester operand b, same slicing as req_a.
- resp_valid  out  NREQ  one-hot, one-cycle result strobe.
- resp_data  out  32  result word, valid while any resp_valid bit is high.
- resp_err  out  1  timeout flag, qualified by resp_valid.
- sp_a  out  32  to ieee754_sp input a.
- sp_b  out  32  to ieee754_sp input b.
- sp_op  out  2  to ieee754_sp op.
- sp_go  out  1  to ieee754_sp go.
- sp_done  in  1  from ieee754_sp done.
- sp_d  in  32  from ieee754_sp result d.
- busy  out  1  high in every state except IDLE.
- timeout_cnt  out  8  saturating count of aborted operations.

Behaviour:
- Reset values (asynchronous reset):
  - req_ready=0, resp_valid=0, resp_data=0, resp_err=0.
  - sp_go=0, sp_a=0, sp_b=0, sp_op=0.
  - busy=0, timeout_cnt=0.
  - Round-robin pointer=0, state=IDLE.
- Reset asserted mid-operation abandons the operation silently: no response is produced, and any later sp_done is ignored because the FSM is in IDLE.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready is one-hot on the winner: the first set req_valid bit found searching upward from ptr, with wrap-around. It is all-zero if no request is valid.
  - req_ready is combinational from req_valid, ptr and state; it is never asserted outside IDLE.
  - On a handshake at edge T, latch op, a, b and the winner index id, then go to ISSUE.
- ISSUE (cycle T+1):
  - sp_go=1 for exactly this cycle.
  - sp_a, sp_b and sp_op are driven from the latched registers and stay stable until the FSM returns to IDLE.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - sp_go=0 and the watchdog increments every cycle.
  - If sp_done=1, latch sp_d into the result register, clear the error flag and go to RESP.
  - Otherwise, when the watchdog reaches TIMEOUT-1, set the error flag, load result=32'h7FC00000 (qNaN), increment timeout_cnt (saturating at 255) and go to RESP.
  - If sp_done and the timeout coincide, done wins and no error is flagged.
- RESP:
  - resp_valid[id]=1 for exactly one cycle, with resp_data and resp_err presented in the same cycle.
  - Set ptr=(id+1) mod NREQ and go to IDLE.
  - resp_data and resp_err hold their value after RESP; resp_valid returns to 0.
- sp_done seen in IDLE, ISSUE or RESP is a stale pulse from an aborted operation and is ignored.
- Minimum occupancy: 3 cycles plus the unit latency. With a 1-cycle unit, requests are accepted back-to-back every 4 cycles.
- Requester rules:
  - A requester must hold req_valid and its operands stable until it receives req_ready.
  - Dropping req_valid before the grant is legal; the arbiter re-evaluates every cycle in IDLE.
  - Operand changes after acceptance have no effect.
- A requester may assert req_valid again in the same cycle its resp_valid is high. It is then the lowest priority for that arbitration, because ptr has already moved past it.
- Widths:
  - ptr and id are clog2(NREQ) bits.
  - The watchdog is clog2(TIMEOUT) bits, compared against TIMEOUT-1.

Decomposition:
- Package fpu_arb_pkg:
  - SP_MULT=0, SP_DIV=1, SP_ADD=2, SP_SUB=3.
  - State encoding IDLE/ISSUE/WAIT/RESP.
  - QNAN=32'h7FC00000.
- Sub-module rr_pick (combinational):
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, binary index and any.
  - Instantiated once; verified standalone for every ptr value.

Test Plan:
- Single request: req0 ADD a=0x3F800000 (1.0), b=0x40000000 (2.0), model done after 5 cycles with d=0x40400000 -> req_ready[0] one cycle; sp_go exactly one cycle at T+1 with sp_op=2; resp_valid[0] with resp_data=0x40400000, resp_err=0.
- Contention: req0..req3 all valid from reset, each held until granted -> grants in order 0,1,2,3 with ptr wrapping; each resp_valid one-hot matches its grant; sp_a/sp_b never change between ISSUE and RESP.
- Round-robin fairness: req1 continuously valid, req2 valid once -> after req1 is served, req2 is granted before req1 again.
- Timeout: model never asserts done, TIMEOUT=8 -> resp_valid on the issuing requester 8 cycles after sp_go, resp_data=0x7FC00000, resp_err=1, timeout_cnt=1; a stale sp_done injected afterwards in IDLE is ignored.
- Coincidence: done arrives on the same cycle the watchdog hits TIMEOUT-1 -> resp_err=0, resp_data=sp_d, timeout_cnt unchanged.
- Reset mid-WAIT: reset asserted while an FDV is in WAIT, later sp_done pulsed -> all outputs at reset values; no resp_valid; next request is granted starting from ptr=0.

Source files
------------

// File: rtl/fpu_share_arbiter_pkg.sv
// fpu_arb_pkg: opcodes, FSM states and the timeout result word shared by the FPU arbiter.
package fpu_arb_pkg;
    localparam logic [1:0] SP_MULT = 2'd0;
    localparam logic [1:0] SP_DIV  = 2'd1;
    localparam logic [1:0] SP_ADD  = 2'd2;
    localparam logic [1:0] SP_SUB  = 2'd3;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/fpu_share_arbiter_if.sv
// fpu_share_arbiter_if: requester bus plus the ieee754_sp go/done link; slave is the arbiter side.
interface fpu_share_arbiter_if #(parameter int NREQ = 4);
    import fpu_arb_pkg::*;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_data;
    logic                 resp_err;
    logic [31:0]          sp_a;
    logic [31:0]          sp_b;
    logic [1:0]           sp_op;
    logic                 sp_go;
    logic                 sp_done;
    logic [31:0]          sp_d;
    modport master (
        output req_valid, req_op, req_a, req_b, sp_done, sp_d,
        input  req_ready, resp_valid, resp_data, resp_err, sp_a, sp_b, sp_op, sp_go
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, sp_done, sp_d,
        output req_ready, resp_valid, resp_data, resp_err, sp_a, sp_b, sp_op, sp_go
    );
endinterface

// File: rtl/fpu_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap-around.
module rr_pick
    import fpu_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_any
);
    logic [W-1:0] w_j;
    // Scan farthest-first so the candidate closest to ptr is the last one written.
    always_comb begin
        w_j   = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = W'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) begin
                o_idx = w_j;
                o_any = 1'b1;
            end
        end
        o_gnt = o_any ? N'(1) << o_idx : '0;
    end
endmodule

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one ieee754_sp unit among NREQ requesters,
// with a watchdog that turns a hung unit into a qNaN error response.
module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    fpu_share_arbiter_if.slave  bus,
    output logic                busy,
    output logic [7:0]          timeout_cnt
);
    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT);

    state_t            r_state, w_next;
    logic [IW-1:0]     r_ptr, r_id, w_idx;
    logic [NREQ-1:0]   w_gnt;
    logic              w_any;
    logic [1:0]        r_op;
    logic [31:0]       r_a, r_b, r_res;
    logic              r_err;
    logic [WW-1:0]     r_wd;
    logic [7:0]        r_tcnt;
    logic              w_timeout;

    rr_pick #(.N(NREQ)) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Abort when the count after this cycle's increment reaches TIMEOUT-1.
    assign w_timeout = (r_wd + WW'(1)) == WW'(TIMEOUT - 1);

    assign bus.req_ready  = (r_state == IDLE) ? w_gnt : '0;
    assign bus.resp_valid = (r_state == RESP) ? NREQ'(1) << r_id : '0;
    assign bus.resp_data  = r_res;
    assign bus.resp_err   = r_err;
    assign bus.sp_a       = r_a;
    assign bus.sp_b       = r_b;
    assign bus.sp_op      = r_op;
    assign bus.sp_go      = r_state == ISSUE;
    assign busy           = r_state != IDLE;
    assign timeout_cnt    = r_tcnt;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_any ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (bus.sp_done || w_timeout) ? RESP : WAIT;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_wd    <= '0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_any) begin
                    r_id <= w_idx;
                    r_op <= bus.req_op[2*int'(w_idx) +: 2];
                    r_a  <= bus.req_a[32*int'(w_idx) +: 32];
                    r_b  <= bus.req_b[32*int'(w_idx) +: 32];
                end
                ISSUE: r_wd <= '0;
                WAIT: begin
                    r_wd <= r_wd + WW'(1);
                    if (bus.sp_done) begin
                        r_res <= bus.sp_d;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_res <= QNAN;
                        r_err <= 1'b1;
                        if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                RESP: r_ptr <= (int'(r_id) == NREQ - 1) ? '0 : r_id + IW'(1);
                default: ;
            endcase
        end
    end
endmodule
